// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/WAIT/EXEC/WB/HALT sequencer for the accumulator CPU; define CTRL_RETIRE_CNT_EN to add RetireCount
module multicycle_controller #(
  parameter int OPERAND_W   = 4,
  parameter int ALU_SEL_W   = 4,
  parameter int DECODE_WAIT = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   InstrReady,
  input  logic [3+OPERAND_W:0]   Opcode,
  input  logic                   Zero,
  input  logic                   Carry,
  output logic                   LoadIR,
  output logic                   IncPC,
  output logic                   SelPC,
  output logic                   LoadPC,
  output logic                   LoadReg,
  output logic                   DumpReg,
  output logic                   LoadAcc,
  output logic                   DumpAcc,
  output logic [1:0]             SelAcc,
  output logic [ALU_SEL_W-1:0]   SelALU,
  output logic [OPERAND_W-1:0]   ImmediateData,
  output logic [OPERAND_W-1:0]   RegNumber,
  output logic                   Halted,
  output logic                   Illegal
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]       RetireCount
`endif
);
  localparam int IW = 4 + OPERAND_W;
  localparam int CW = DECODE_WAIT > 1 ? $clog2(DECODE_WAIT + 1) : 1;
  typedef enum logic [2:0] {FETCH, WAIT, EXEC, WB, HALT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] op_q;
  logic z_q, c_q;
  logic [3:0] opc;
  logic in_ex, in_wb, latch, reg_alu, alu_op, taken, imm_jump;
  logic [ALU_SEL_W-1:0] alu_sel;
  assign opc   = op_q[IW-1 -: 4];
  assign in_ex = state == EXEC;
  assign in_wb = state == WB;
  // Opcode and flags are captured on the edge entering EXEC, whichever state precedes it
  assign latch = (state == FETCH && InstrReady && DECODE_WAIT == 0) || (state == WAIT && cnt == CW'(1));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= CW'(DECODE_WAIT);
      op_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FETCH) cnt <= CW'(DECODE_WAIT);
      else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (latch) begin
        op_q <= Opcode;
        z_q  <= Zero;
        c_q  <= Carry;
      end
    end
  end
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:   state_n = InstrReady ? (DECODE_WAIT == 0 ? EXEC : WAIT) : FETCH;
      WAIT:    state_n = cnt == CW'(1) ? EXEC : WAIT;
      EXEC:    state_n = opc == 4'hF ? HALT : alu_op ? WB : FETCH;
      WB:      state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end
  assign reg_alu  = opc == 4'h1 || opc == 4'h2 || opc == 4'h3;
  assign alu_op   = reg_alu || opc == 4'hC || opc == 4'hB;
  assign alu_sel  = opc == 4'h2 ? ALU_SEL_W'(4'b0001) :
                    opc == 4'h3 ? ALU_SEL_W'(4'b1000) :
                    opc == 4'hC ? ALU_SEL_W'(4'b1100) :
                    opc == 4'hB ? ALU_SEL_W'(4'b1101) : '0;
  assign taken    = ((opc == 4'h6 || opc == 4'h7) && z_q) || ((opc == 4'h8 || opc == 4'hA) && c_q);
  assign imm_jump = opc == 4'h7 || opc == 4'hA;
  assign LoadIR        = state == FETCH && InstrReady;
  assign LoadPC        = in_ex && taken;
  assign SelPC         = in_ex && taken && imm_jump;
  assign IncPC         = in_wb || (in_ex && !taken && !alu_op && opc != 4'hF);
  assign LoadReg       = in_ex && opc == 4'h5;
  assign DumpAcc       = in_ex && opc == 4'h5;
  assign DumpReg       = (in_ex && (opc == 4'h4 || reg_alu)) || (in_wb && reg_alu);
  assign LoadAcc       = in_wb || (in_ex && (opc == 4'h4 || opc == 4'hD));
  assign SelAcc        = in_wb ? 2'b10 : (in_ex && opc == 4'h4) ? 2'b01 : 2'b00;
  assign SelALU        = (in_ex || in_wb) && alu_op ? alu_sel : '0;
  assign ImmediateData = in_ex || in_wb ? op_q[OPERAND_W-1:0] : '0;
  assign RegNumber     = in_ex || in_wb ? op_q[OPERAND_W-1:0] : '0;
  assign Halted        = state == HALT;
  assign Illegal       = in_ex && (opc == 4'h9 || opc == 4'hE);
`ifdef CTRL_RETIRE_CNT_EN
  logic retire;
  assign retire = (in_ex && !alu_op) || in_wb;
  always_ff @(posedge clk) begin
    if (reset) RetireCount <= '0;
    else if (retire) RetireCount <= RetireCount + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  localparam int DW = 4;
  localparam int H  = 6;
  typedef struct packed {
    logic lir, inc, selpc, ldpc, ldreg, dreg, lacc, dacc;
    logic [1:0] sacc;
    logic [3:0] alu, imm, rn;
    logic h, ill;
  } ov_t;
  typedef struct packed { int cyc; ov_t v; } ev_t;
  typedef struct packed { int cyc; logic lir, inc; logic [1:0] rc; } ev1_t;
  logic clk = 0, reset = 1, InstrReady = 0, Zero = 0, Carry = 0;
  logic [7:0] Opcode = '0;
  logic LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc, DumpAcc, Halted, Illegal;
  logic [1:0] SelAcc;
  logic [3:0] SelALU, ImmediateData, RegNumber;
  ov_t obs;
  logic r1 = 1, ir1 = 0;
  logic [7:0] op1 = '0;
  logic lir1, inc1, selpc1, ldpc1, ldreg1, dreg1, lacc1, dacc1, h1, ill1;
  logic [1:0] sacc1, rc1;
  logic [3:0] alu1, imm1, rn1;
  int cyc = 0, checks = 0, errors = 0;
  bit mon_en = 0;
  ev_t sb[$];
  ev1_t sb1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  multicycle_controller #(.OPERAND_W(4), .ALU_SEL_W(4), .DECODE_WAIT(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .InstrReady(InstrReady), .Opcode(Opcode), .Zero(Zero), .Carry(Carry),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
    .DumpReg(DumpReg), .LoadAcc(LoadAcc), .DumpAcc(DumpAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .ImmediateData(ImmediateData), .RegNumber(RegNumber), .Halted(Halted), .Illegal(Illegal)
`ifdef CTRL_RETIRE_CNT_EN
    , .RetireCount()
`endif
  );
  multicycle_controller #(.OPERAND_W(4), .ALU_SEL_W(4), .DECODE_WAIT(0), .CNT_W(2)) u1 (
    .clk(clk), .reset(r1), .InstrReady(ir1), .Opcode(op1), .Zero(1'b0), .Carry(1'b0),
    .LoadIR(lir1), .IncPC(inc1), .SelPC(selpc1), .LoadPC(ldpc1), .LoadReg(ldreg1),
    .DumpReg(dreg1), .LoadAcc(lacc1), .DumpAcc(dacc1), .SelAcc(sacc1), .SelALU(alu1),
    .ImmediateData(imm1), .RegNumber(rn1), .Halted(h1), .Illegal(ill1)
`ifdef CTRL_RETIRE_CNT_EN
    , .RetireCount(rc1)
`endif
  );
`ifndef CTRL_RETIRE_CNT_EN
  assign rc1 = '0;
`endif
  assign obs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc, DumpAcc,
                SelAcc, SelALU, ImmediateData, RegNumber, Halted, Illegal};

  // Instruction table: what the datapath should see in the EXEC cycle and, for ALU ops, the WB cycle
  function automatic void model(input logic [7:0] op, input logic z, c, output ov_t ex, output ov_t wb, output bit alu);
    logic [3:0] hi;
    hi = op[7:4];
    ex = '0; wb = '0; alu = 0;
    ex.imm = op[3:0]; ex.rn = op[3:0];
    case (hi)
      4'h0: ex.inc = 1;
      4'h4: begin ex.dreg = 1; ex.lacc = 1; ex.sacc = 2'b01; ex.inc = 1; end
      4'h5: begin ex.dacc = 1; ex.ldreg = 1; ex.inc = 1; end
      4'hD: begin ex.lacc = 1; ex.sacc = 2'b00; ex.inc = 1; end
      4'h6, 4'h7: if (z) begin ex.ldpc = 1; ex.selpc = hi == 4'h7; end else ex.inc = 1;
      4'h8, 4'hA: if (c) begin ex.ldpc = 1; ex.selpc = hi == 4'hA; end else ex.inc = 1;
      4'h1: begin alu = 1; ex.dreg = 1; ex.alu = 4'b0000; end
      4'h2: begin alu = 1; ex.dreg = 1; ex.alu = 4'b0001; end
      4'h3: begin alu = 1; ex.dreg = 1; ex.alu = 4'b1000; end
      4'hC: begin alu = 1; ex.alu = 4'b1100; end
      4'hB: begin alu = 1; ex.alu = 4'b1101; end
      4'h9, 4'hE: begin ex.inc = 1; ex.ill = 1; end
      default: ;
    endcase
    if (alu) begin wb = ex; wb.lacc = 1; wb.sacc = 2'b10; wb.inc = 1; end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        ev_t e;
        e = sb.pop_front();
        if (obs !== e.v) begin
          errors++;
          $display("FAIL event cyc %0d got %h expected %h", cyc, obs, e.v);
        end
      end else if (obs !== '0) begin
        errors++;
        $display("FAIL idle cyc %0d got %h expected 0", cyc, obs);
      end
    end
    if (sb1.size() != 0 && sb1[0].cyc == cyc) begin
      ev1_t e1;
      logic ok;
      e1 = sb1.pop_front();
      checks++;
      ok = lir1 === e1.lir && inc1 === e1.inc;
`ifdef CTRL_RETIRE_CNT_EN
      ok = ok && rc1 === e1.rc;
`endif
      if (!ok) begin
        errors++;
        $display("FAIL nop_stream cyc %0d got lir=%b inc=%b rc=%0d expected lir=%b inc=%b rc=%0d",
                 cyc, lir1, inc1, rc1, e1.lir, e1.inc, e1.rc);
      end
    end
  end

  task automatic do_reset(input int n);
    mon_en = 0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover cyc %0d got %0d pending expected 0", cyc, sb.size());
      sb.delete();
    end
    reset = 1; InstrReady = 0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_out cyc %0d got %h expected 0", cyc, obs);
    end
    mon_en = 1;
  endtask

  // Called at #1 into a FETCH cycle; returns at #1 into the next FETCH cycle
  task automatic issue(input logic [7:0] op, input logic z, c, input int idle, input bit rst_wb);
    ov_t ex, wb, lv, hv;
    bit alu;
    int t;
    model(op, z, c, ex, wb, alu);
    repeat (idle) begin @(posedge clk); #1; end
    InstrReady = 1; Opcode = op; Zero = z; Carry = c; t = cyc;
    lv = '0; lv.lir = 1;
    sb.push_back('{t, lv});
    if (ex != '0) sb.push_back('{t + DW + 1, ex});
    if (alu && !rst_wb) sb.push_back('{t + DW + 2, wb});
    if (op[7:4] == 4'hF) begin
      hv = '0; hv.h = 1;
      for (int i = 0; i < H; i++) sb.push_back('{t + DW + 2 + i, hv});
    end
    @(posedge clk); #1;
    repeat (DW) begin InstrReady = 1'($urandom); @(posedge clk); #1; end
    {InstrReady, Zero, Carry} = 3'($urandom);
    Opcode = 8'($urandom);
    @(posedge clk); #1;
    if (op[7:4] == 4'hF) begin
      repeat (H) begin InstrReady = 1'($urandom); @(posedge clk); #1; end
      do_reset(2);
    end else if (alu) begin
      if (rst_wb) do_reset(3);
      else begin InstrReady = 1'($urandom); @(posedge clk); #1; end
    end
    InstrReady = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    do_reset(3);
    issue(8'hD7, 0, 0, 0, 0);
    issue(8'h73, 1, 0, 5, 0);
    issue(8'h73, 0, 1, 0, 0);
    issue(8'h62, 1, 1, 1, 0);
    issue(8'hA5, 0, 1, 0, 0);
    issue(8'h85, 1, 0, 0, 0);
    issue(8'h12, 0, 0, 0, 0);
    issue(8'h12, 1, 1, 0, 1);
    issue(8'h9C, 0, 0, 2, 0);
    issue(8'hE1, 1, 0, 0, 0);
    issue(8'h4A, 0, 0, 0, 0);
    issue(8'h53, 0, 0, 0, 0);
    issue(8'hC0, 0, 0, 0, 0);
    issue(8'hB9, 0, 0, 0, 0);
    issue(8'h3F, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      issue({4'($urandom_range(0, 14)), 4'($urandom)}, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
    issue(8'hF0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      issue({4'($urandom_range(0, 14)), 4'($urandom)}, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
    issue(8'hF7, 1, 1, 0, 0);
    issue(8'h05, 0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    // DECODE_WAIT=0 instance: back-to-back NOPs, two cycles each
    @(posedge clk); #1;
    r1 = 0; ir1 = 1; op1 = {4'h0, 4'($urandom)}; t = cyc;
    for (int k = 0; k < 5; k++) begin
      sb1.push_back('{t + 2 * k, 1'b1, 1'b0, 2'(k)});
      sb1.push_back('{t + 2 * k + 1, 1'b0, 1'b1, 2'(k)});
    end
    sb1.push_back('{t + 10, 1'b1, 1'b0, 2'(5)});
    repeat (11) begin @(posedge clk); #1; end
    ir1 = 0;
    checks++;
    if (sb1.size() != 0) begin
      errors++;
      $display("FAIL nop_drain got %0d pending expected 0", sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
